// File: rtl/fifo_rd_stream.sv
// Read-side FIFO consumer: pops the FIFO with in-flight accounting and re-presents words as a valid/ready stream.
// Optional macro STREAM_PARITY_EN adds m_parity, stored per buffer entry at capture.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  r_clk,
    input  logic                  r_rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_r_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    input  logic                  flush,
`ifdef STREAM_PARITY_EN
    output logic                  m_parity,
`endif
    output logic [CNT_WIDTH-1:0]  word_count
);

    localparam int PTR_W = (BUF_DEPTH > 2) ? 2 : 1;
    localparam logic [3:0] DEPTH_V = 4'(BUF_DEPTH);

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] buf_data [BUF_DEPTH];
`ifdef STREAM_PARITY_EN
    logic                  buf_par  [BUF_DEPTH];
`endif
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [2:0]            occupancy;
    logic [2:0]            occ_next;
    logic [3:0]            demand;
    logic                  inflight;
    logic                  pop;
    logic                  issue;
    logic                  capture;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Issue only if the word, once landed, is guaranteed a free buffer slot.
    always_comb begin
        pop     = m_valid && m_ready;
        demand  = {1'b0, occupancy} + {3'b000, inflight} - {3'b000, pop};
        issue   = r_rst_n && !fifo_empty && !flush && (state != FLUSH) && (demand < DEPTH_V);
        capture = inflight && !flush && (state != FLUSH);
        occ_next = occupancy;
        if (flush) begin
            occ_next = 3'd0;
        end else if (capture && !pop) begin
            occ_next = occupancy + 3'd1;
        end else if (!capture && pop) begin
            occ_next = occupancy - 3'd1;
        end
    end

    assign fifo_r_en = issue;
    assign m_valid   = (occupancy != 3'd0);
    assign m_data    = buf_data[head];
`ifdef STREAM_PARITY_EN
    assign m_parity  = buf_par[head];
`endif

    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            state      <= IDLE;
            head       <= '0;
            tail       <= '0;
            occupancy  <= 3'd0;
            inflight   <= 1'b0;
            word_count <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_data[i] <= '0;
`ifdef STREAM_PARITY_EN
                buf_par[i]  <= 1'b0;
`endif
            end
        end else begin
            inflight  <= issue;
            occupancy <= occ_next;
            // A handshake completing alongside flush still counts.
            if (pop) begin
                word_count <= word_count + CNT_WIDTH'(1);
            end
            if (flush) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (capture) begin
                    buf_data[tail] <= fifo_data;
`ifdef STREAM_PARITY_EN
                    buf_par[tail]  <= ^fifo_data;
`endif
                    tail <= next_ptr(tail);
                end
                if (pop) begin
                    head <= next_ptr(head);
                end
            end
            if (flush) begin
                state <= FLUSH;
            end else begin
                case (state)
                    IDLE:    if (issue) state <= ACTIVE;
                    ACTIVE:  if (!issue && occ_next == 3'd0) state <= IDLE;
                    FLUSH:   if (!inflight) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based FIFO environment, queue-level reference model checked every cycle,
// plus directed scenarios with literal expectations. Parity checks enabled when STREAM_PARITY_EN is defined.
module tb_fifo_rd_stream;

    localparam int DW    = 8;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;

    logic             r_clk = 1'b0;
    logic             r_rst_n;
    logic             fifo_empty;
    logic [DW-1:0]    fifo_data;
    logic             fifo_r_en;
    logic [DW-1:0]    m_data;
    logic             m_valid;
    logic             m_ready;
    logic             flush;
    logic [CNT_W-1:0] word_count;
`ifdef STREAM_PARITY_EN
    logic             m_parity;
`endif

    fifo_rd_stream #(.DATA_WIDTH(DW), .BUF_DEPTH(DEPTH), .CNT_WIDTH(CNT_W)) dut (
        .r_clk      (r_clk),
        .r_rst_n    (r_rst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_r_en  (fifo_r_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .flush      (flush),
`ifdef STREAM_PARITY_EN
        .m_parity   (m_parity),
`endif
        .word_count (word_count)
    );

    always #5 r_clk = ~r_clk;

    int tests_run = 0;
    int tests_failed = 0;

    logic [DW-1:0] env_q[$];
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] mbuf[$];
    logic          m_inflight;
    logic [DW-1:0] m_inflight_word;
    logic          m_flushing;
    int            m_count;

    logic          last_r_en;
    logic          last_valid;
    logic [DW-1:0] last_data;
    logic [CNT_W-1:0] last_count;
    logic          last_parity;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        env_q.push_back(w);
        src_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic do_reset();
        r_rst_n = 1'b0;
        flush = 1'b0;
        m_ready = 1'b0;
        env_q.delete();
        src_q.delete();
        mbuf.delete();
        m_inflight = 1'b0;
        m_inflight_word = '0;
        m_flushing = 1'b0;
        m_count = 0;
        fifo_empty = 1'b1;
        fifo_data = '0;
        repeat (2) @(posedge r_clk);
        #1;
        r_rst_n = 1'b1;
    endtask

    // One clock cycle: compare against the model mid-cycle, then advance model and FIFO environment.
    task automatic apply_stimulus();
        logic exp_pop, exp_r_en, r_en_s, flush_s;
        int   demand;
        @(negedge r_clk);
        exp_pop  = (mbuf.size() != 0) && m_ready;
        demand   = mbuf.size() + int'(m_inflight) - int'(exp_pop);
        exp_r_en = !fifo_empty && !flush && !m_flushing && (demand < DEPTH);
        check_output("fifo_r_en", 32'(fifo_r_en), 32'(exp_r_en));
        check_output("m_valid", 32'(m_valid), 32'(mbuf.size() != 0));
        if (mbuf.size() != 0) begin
            check_output("m_data", 32'(m_data), 32'(mbuf[0]));
`ifdef STREAM_PARITY_EN
            check_output("m_parity", 32'(m_parity), 32'(^mbuf[0]));
`endif
        end
        check_output("word_count", 32'(word_count), 32'(m_count % (1 << CNT_W)));
        last_r_en  = fifo_r_en;
        last_valid = m_valid;
        last_data  = m_data;
        last_count = word_count;
`ifdef STREAM_PARITY_EN
        last_parity = m_parity;
`else
        last_parity = 1'b0;
`endif
        r_en_s  = fifo_r_en;
        flush_s = flush;
        @(posedge r_clk);
        if (exp_pop) m_count++;
        if (flush_s) begin
            mbuf.delete();
        end else begin
            if (exp_pop) void'(mbuf.pop_front());
            if (m_inflight && !m_flushing) mbuf.push_back(m_inflight_word);
        end
        m_flushing = flush_s || (m_flushing && m_inflight);
        m_inflight = exp_r_en;
        if (exp_r_en && src_q.size() > 0) m_inflight_word = src_q.pop_front();
        #1;
        if (r_en_s && env_q.size() > 0) fifo_data = env_q.pop_front();
        fifo_empty = (env_q.size() == 0);
    endtask

    logic          rec_r_en [16];
    logic          rec_valid[16];
    logic [DW-1:0] rec_data [16];
    int            n_issue;
    int            first_k;

    initial begin
        do_reset();

        // Empty FIFO: nothing issued, nothing presented.
        for (int k = 0; k < 10; k++) begin
            apply_stimulus();
            if (k == 0 || k == 9) begin
                check_output("idle_r_en", 32'(last_r_en), 32'd0);
                check_output("idle_valid", 32'(last_valid), 32'd0);
                check_output("idle_data", 32'(last_data), 32'd0);
                check_output("idle_count", 32'(last_count), 32'd0);
            end
        end

        // Three words, m_ready high: issue on 3 cycles, data from 2 cycles after first issue.
        do_reset();
        push_word(8'h11); push_word(8'h22); push_word(8'h33);
        m_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            apply_stimulus();
            rec_r_en[k] = last_r_en; rec_valid[k] = last_valid; rec_data[k] = last_data;
        end
        check_output("burst3_r_en", {28'd0, rec_r_en[0], rec_r_en[1], rec_r_en[2], rec_r_en[3]}, 32'b1110);
        check_output("burst3_valid", {26'd0, rec_valid[0], rec_valid[1], rec_valid[2], rec_valid[3], rec_valid[4], rec_valid[5]}, 32'b001110);
        check_output("burst3_d0", 32'(rec_data[2]), 32'h11);
        check_output("burst3_d1", 32'(rec_data[3]), 32'h22);
        check_output("burst3_d2", 32'(rec_data[4]), 32'h33);
        check_output("burst3_count", 32'(last_count), 32'd3);

        // Stalled sink: only DEPTH pops, head held stable; then drain without gaps.
        do_reset();
        push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44); push_word(8'h55);
        n_issue = 0;
        for (int k = 0; k < 6; k++) begin
            apply_stimulus();
            n_issue += int'(last_r_en);
            if (k >= 2) check_output("stall_hold", 32'(last_data), 32'h11);
        end
        check_output("stall_issues", 32'(n_issue), 32'(DEPTH));
        m_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            apply_stimulus();
            check_output("drain_valid", 32'(last_valid), 32'd1);
            check_output("drain_data", 32'(last_data), 32'h11 * (k + 1));
        end

        // Flush with one buffered word and one in flight: both dropped, 4th word comes next.
        do_reset();
        push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44); push_word(8'h55);
        repeat (3) apply_stimulus();
        m_ready = 1'b1;
        apply_stimulus();
        m_ready = 1'b0;
        flush = 1'b1;
        apply_stimulus();
        flush = 1'b0;
        m_ready = 1'b1;
        apply_stimulus();
        check_output("flush_valid", 32'(last_valid), 32'd0);
        check_output("flush_count", 32'(last_count), 32'd1);
        first_k = -1;
        for (int k = 0; k < 8 && first_k < 0; k++) begin
            apply_stimulus();
            if (last_valid) begin
                first_k = k;
                check_output("flush_next_word", 32'(last_data), 32'h44);
                check_output("flush_next_count", 32'(last_count), 32'd1);
            end
        end
        if (first_k < 0) check_output("flush_resume_timeout", 32'd0, 32'd1);

        // Asynchronous reset between edges.
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) push_word(8'(8'hA0 + i));
        repeat (4) apply_stimulus();
        #2;
        r_rst_n = 1'b0;
        #1;
        check_output("async_r_en", 32'(fifo_r_en), 32'd0);
        check_output("async_valid", 32'(m_valid), 32'd0);
        check_output("async_data", 32'(m_data), 32'd0);
        check_output("async_count", 32'(word_count), 32'd0);
        do_reset();
        m_ready = 1'b1;
        push_word(8'h5A); push_word(8'hC3);
        repeat (5) apply_stimulus();
        check_output("post_reset_count", 32'(last_count), 32'd2);

        // Counter wrap: 17 words into a 4-bit counter.
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 17; i++) push_word(8'(i * 7 + 1));
        repeat (22) apply_stimulus();
        check_output("wrap_count", 32'(last_count), 32'd1);

`ifdef STREAM_PARITY_EN
        do_reset();
        m_ready = 1'b1;
        push_word(8'h07); push_word(8'h03);
        for (int k = 0; k < 4; k++) begin
            apply_stimulus();
            if (k == 2) check_output("parity_07", 32'(last_parity), 32'd1);
            if (k == 3) check_output("parity_03", 32'(last_parity), 32'd0);
        end
`endif

        // Randomized traffic with occasional flush and bursts of full-rate sink.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 3) != 0 && env_q.size() < 8) push_word(8'($urandom_range(0, 255)));
            if ((c / 200) % 2 == 1) m_ready = 1'b1;
            else m_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 29) == 0);
            apply_stimulus();
        end
        flush = 1'b0;
        m_ready = 1'b1;
        repeat (20) apply_stimulus();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
